// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter sequencer and its return-address stack.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        SRC_RESET,
        SRC_REDIRECT,
        SRC_HOLD,
        SRC_RETURN,
        SRC_TARGET,
        SRC_SEQ
    } pc_src_e;

    // Bits needed to hold an entry count from 0 up to and including depth.
    function automatic int unsigned ras_cnt_w(input int unsigned depth);
        return unsigned'($clog2(depth + 1));
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the pipeline and the PC sequencer.
interface pc_sequencer_if
    import pc_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CW = ras_cnt_w(RAS_DEPTH);

    logic             WriteEn;
    logic             Branch;
    logic             ALUZero;
    logic             Unconditional;
    logic             Link;
    logic             Return;
    logic             Redirect;
    logic [WIDTH-1:0] RedirectPC;
    logic [WIDTH-1:0] SignExtImm;
    logic [WIDTH-1:0] PC;
    logic             Taken;
    logic             RasUnderflow;
    logic [CW-1:0]    RasCount;
    logic             RasEmpty;
    logic             RasFull;

    modport master (
        output WriteEn, Branch, ALUZero, Unconditional, Link, Return,
               Redirect, RedirectPC, SignExtImm,
        input  PC, Taken, RasUnderflow, RasCount, RasEmpty, RasFull
    );

    modport slave (
        input  WriteEn, Branch, ALUZero, Unconditional, Link, Return,
               Redirect, RedirectPC, SignExtImm,
        output PC, Taken, RasUnderflow, RasCount, RasEmpty, RasFull
    );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a full push overwrites the oldest entry.
module ras_stack
    import pc_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic                               Push,
    input  logic                               Pop,
    input  logic [WIDTH-1:0]                   PushData,
    output logic [WIDTH-1:0]                   Top,
    output logic [ras_cnt_w(RAS_DEPTH)-1:0]    Count,
    output logic                               Empty,
    output logic                               Full
);
    localparam int unsigned CW = ras_cnt_w(RAS_DEPTH);
    localparam int unsigned PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d, wr_idx;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wr_en;

    // Push+Pop together rewrites the top slot in place; pointer wrap is free (power-of-two depth).
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (Push && Pop) begin
            wr_en = 1'b1;
            if (cnt_q == CW'(0)) cnt_d = CW'(1);
        end else if (Push) begin
            ptr_d  = ptr_q + PW'(1);
            wr_idx = ptr_q + PW'(1);
            wr_en  = 1'b1;
            if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
        end else if (Pop && (cnt_q != CW'(0))) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge Clk) begin
        if (!Reset && wr_en) mem_q[wr_idx] <= PushData;
    end

    assign Top   = mem_q[ptr_q];
    assign Count = cnt_q;
    assign Empty = (cnt_q == CW'(0));
    assign Full  = (cnt_q == CW'(RAS_DEPTH));

endmodule

// File: rtl/pc_sequencer.sv
// PC register with priority next-PC selection, PC-relative target adder and return-address stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned      WIDTH        = 64,
    parameter int unsigned      INSTR_BYTES  = 4,
    parameter int unsigned      IMM_SHIFT    = 2,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    pc_sequencer_if.slave  bus
);
    localparam int unsigned CW = ras_cnt_w(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] seq_pc, tgt_pc, ras_top;
    logic             taken_q, taken_d;
    logic             unf_q, unf_d;
    logic             push, pop;
    logic             ras_empty, ras_full;
    logic [CW-1:0]    ras_count;
    pc_src_e          src;

    assign seq_pc = pc_q + WIDTH'(INSTR_BYTES);
    assign tgt_pc = pc_q + (bus.SignExtImm << IMM_SHIFT);

    // Priority decode: reset > redirect > stall > return > taken target > sequential.
    always_comb begin
        src   = SRC_SEQ;
        unf_d = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        if (Reset) begin
            src = SRC_RESET;
        end else if (bus.Redirect) begin
            src = SRC_REDIRECT;
        end else if (!bus.WriteEn) begin
            src = SRC_HOLD;
        end else begin
            push = bus.Link;
            if (bus.Return) begin
                pop   = !ras_empty;
                unf_d = ras_empty;
                src   = ras_empty ? SRC_SEQ : SRC_RETURN;
            end else if (bus.Link || bus.Unconditional || (bus.Branch && bus.ALUZero)) begin
                src = SRC_TARGET;
            end
        end
    end

    always_comb begin
        pc_d    = seq_pc;
        taken_d = 1'b0;
        case (src)
            SRC_RESET:    pc_d = RESET_VECTOR;
            SRC_REDIRECT: begin pc_d = bus.RedirectPC; taken_d = 1'b1; end
            SRC_HOLD:     pc_d = pc_q;
            SRC_RETURN:   begin pc_d = ras_top;        taken_d = 1'b1; end
            SRC_TARGET:   begin pc_d = tgt_pc;         taken_d = 1'b1; end
            default:      pc_d = seq_pc;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q    <= RESET_VECTOR;
            taken_q <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
            unf_q   <= unf_d;
        end
    end

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .Clk      (Clk),
        .Reset    (Reset),
        .Push     (push),
        .Pop      (pop),
        .PushData (seq_pc),
        .Top      (ras_top),
        .Count    (ras_count),
        .Empty    (ras_empty),
        .Full     (ras_full)
    );

    assign bus.PC           = pc_q;
    assign bus.Taken        = taken_q;
    assign bus.RasUnderflow = unf_q;
    assign bus.RasCount     = ras_count;
    assign bus.RasEmpty     = ras_empty;
    assign bus.RasFull      = ras_full;

endmodule
